// File: rtl/da_lut_loader_if.sv
// Coefficient stream and LUT write port of the DA FIR LUT loader.
// master = coefficient source / LUT storage side, slave = loader side.
interface da_lut_loader_if #(
    parameter int unsigned OPSIZE = 12,
    parameter int unsigned TAPS   = 3,
    parameter int unsigned NSUB   = 2
);
    localparam int unsigned LUTW = OPSIZE + $clog2(TAPS);
    localparam int unsigned SELW = (NSUB > 1) ? $clog2(NSUB) : 1;

    logic              coef_valid;
    logic [OPSIZE-1:0] coef_data;
    logic              coef_ready;
    logic              lut_we;
    logic [SELW-1:0]   lut_sel;
    logic [TAPS-1:0]   lut_addr;
    logic [LUTW-1:0]   lut_wdata;

    modport master (
        output coef_valid, coef_data,
        input  coef_ready, lut_we, lut_sel, lut_addr, lut_wdata
    );

    modport slave (
        input  coef_valid, coef_data,
        output coef_ready, lut_we, lut_sel, lut_addr, lut_wdata
    );
endinterface

// File: rtl/da_lut_loader.sv
// Loads FIR coefficients and writes every DA partial-sum LUT entry, one per cycle.
// Optional LUT_CHECKSUM_EN adds lut_csum, a running sum of all written entries.
module da_lut_loader #(
    parameter int unsigned OPSIZE = 12,
    parameter int unsigned TAPS   = 3,
    parameter int unsigned NSUB   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    da_lut_loader_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              lut_valid
`ifdef LUT_CHECKSUM_EN
    ,
    output logic [OPSIZE+$clog2(TAPS)+TAPS-1:0] lut_csum
`endif
);
    localparam int unsigned LUTW  = OPSIZE + $clog2(TAPS);
    localparam int unsigned SELW  = (NSUB > 1) ? $clog2(NSUB) : 1;
    localparam int unsigned NCOEF = NSUB * TAPS;
    localparam int unsigned KW    = (NCOEF > 1) ? $clog2(NCOEF) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StBuild, StDone} state_e;

    state_e                   state_q, state_d;
    logic signed [OPSIZE-1:0] coef_q [NCOEF];
    logic [KW-1:0]            k_q, k_d;
    logic [SELW-1:0]          sel_q, sel_d;
    logic [TAPS-1:0]          addr_q, addr_d;
    logic signed [LUTW-1:0]   wdata_q, wdata_d;
    logic                     lut_valid_q, lut_valid_d;
    logic                     hs, last_coef, last_entry;

    assign hs         = bus.coef_valid && (state_q == StLoad);
    assign last_coef  = (k_q == KW'(NCOEF - 1));
    assign last_entry = (sel_q == SELW'(NSUB - 1)) && (addr_q == '1);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lut_valid_d = lut_valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    k_d         = '0;
                    lut_valid_d = 1'b0;
                end
            end
            StLoad: begin
                if (hs) begin
                    k_d = k_q + KW'(1);
                    // Address 0 is always zero, so the first write needs no coefficients.
                    if (last_coef) begin
                        state_d = StBuild;
                        sel_d   = '0;
                        addr_d  = '0;
                        wdata_d = '0;
                    end
                end
            end
            StBuild: begin
                if (last_entry) begin
                    state_d = StDone;
                end else begin
                    if (addr_q == '1) begin
                        sel_d  = sel_q + SELW'(1);
                        addr_d = '0;
                    end else begin
                        addr_d = addr_q + TAPS'(1);
                    end
                    wdata_d = '0;
                    for (int j = 0; j < int'(TAPS); j++) begin
                        if (addr_d[j]) begin
                            wdata_d = wdata_d + LUTW'(coef_q[KW'(int'(sel_d) * int'(TAPS) + j)]);
                        end
                    end
                end
            end
            StDone: begin
                state_d     = StIdle;
                lut_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lut_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lut_valid_q <= lut_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NCOEF); i++) begin
                coef_q[i] <= '0;
            end
        end else if (hs) begin
            coef_q[k_q] <= bus.coef_data;
        end
    end

    assign bus.coef_ready = (state_q == StLoad);
    assign bus.lut_we     = (state_q == StBuild);
    assign bus.lut_sel    = sel_q;
    assign bus.lut_addr   = addr_q;
    assign bus.lut_wdata  = wdata_q;
    assign busy           = (state_q == StLoad) || (state_q == StBuild);
    assign done           = (state_q == StDone);
    assign lut_valid      = lut_valid_q;

`ifdef LUT_CHECKSUM_EN
    localparam int unsigned CSW = LUTW + TAPS;
    logic [CSW-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            csum_q <= '0;
        end else if (state_q == StBuild) begin
            csum_q <= csum_q + CSW'(wdata_q);
        end
    end

    assign lut_csum = csum_q;
`endif
endmodule
